// File: rtl/uart_char_assembler_if.sv
// Character handshake between the UART frame assembler
// and the microprocessor-side consumer.
interface uart_char_assembler_if;
   logic [7:0] char_out;
   logic       char_valid;
   logic       char_ready;

   modport master (
      output char_out,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  char_out,
      input  char_valid,
      output char_ready
   );
endinterface

// File: rtl/uart_char_assembler.sv
// Frames start/data/parity/stop bits into LSB-first characters
// and holds one character for a valid/ready consumer.
module uart_char_assembler #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bit_in,
   input  logic                         bit_strobe,
   uart_char_assembler_if.master        chr,
   output logic                         frame_err,
   output logic                         parity_err,
   output logic                         overrun,
   output logic                         busy
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                 state, state_n;
   logic [DATA_BITS-1:0]   shift_q, shift_n;
   logic [3:0]             cnt_q, cnt_n;
   logic                   par_q, par_n;
   logic [7:0]             char_q, char_n;
   logic                   valid_q, valid_n;
   logic                   fe_q, fe_n;
   logic                   pe_q, pe_n;
   logic                   ov_q, ov_n;
   logic                   accept;
   logic                   par_bad;
   logic                   last_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         char_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state   <= state_n;
         shift_q <= shift_n;
         cnt_q   <= cnt_n;
         par_q   <= par_n;
         char_q  <= char_n;
         valid_q <= valid_n;
         fe_q    <= fe_n;
         pe_q    <= pe_n;
         ov_q    <= ov_n;
      end
   end

   always_comb begin
      state_n  = state;
      shift_n  = shift_q;
      cnt_n    = cnt_q;
      par_n    = par_q;
      char_n   = char_q;
      valid_n  = valid_q;
      fe_n     = 1'b0;
      pe_n     = 1'b0;
      ov_n     = 1'b0;
      accept   = valid_q && chr.char_ready;
      par_bad  = PARITY_EN && ((^{shift_q, par_q}) != PARITY_ODD);
      last_bit = (cnt_q == 4'(DATA_BITS - 1));

      if (accept) valid_n = 1'b0;

      if (bit_strobe) begin
         unique case (state)
            IDLE: begin
               if (!bit_in) begin
                  state_n = DATA;
                  cnt_n   = '0;
               end
            end
            DATA: begin
               shift_n = {bit_in, shift_q[DATA_BITS-1:1]};
               cnt_n   = cnt_q + 4'd1;
               if (last_bit) state_n = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
               par_n   = bit_in;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               // A bad stop bit drops the character before any other check
               if (!bit_in) begin
                  fe_n = 1'b1;
               end else if (!valid_q || accept) begin
                  char_n  = 8'(shift_q);
                  valid_n = 1'b1;
                  pe_n    = par_bad;
               end else begin
                  ov_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign chr.char_out   = char_q;
   assign chr.char_valid = valid_q;
   assign frame_err      = fe_q;
   assign parity_err     = pe_q;
   assign overrun        = ov_q;
   assign busy           = (state != IDLE);

endmodule
